// File: rtl/lcd_pkg.sv
// Shared constants, step/phase encodings and helpers for the HD44780 text display.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

  typedef enum logic [1:0] {
    PHASE_POWERUP = 2'd0,
    PHASE_INIT    = 2'd1,
    PHASE_REFRESH = 2'd2
  } phase_e;

  // Each step names the transaction that will be issued next.
  typedef enum logic [5:0] {
    STEP_POWERUP  = 6'd0,
    STEP_INIT_1   = 6'd1,
    STEP_INIT_2   = 6'd2,
    STEP_INIT_3   = 6'd3,
    STEP_INIT_4   = 6'd4,
    STEP_INIT_5   = 6'd5,
    STEP_INIT_6   = 6'd6,
    STEP_ROW_ADDR = 6'd7,
    STEP_ROW_DATA = 6'd8
  } step_e;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_SETUP = 2'd1,
    BUS_PULSE = 2'd2,
    BUS_HOLD  = 2'd3
  } bus_state_e;

  function automatic logic [7:0] row_offset(input logic [1:0] row, input int columns);
    case (row)
      2'd0:    row_offset = 8'h00;
      2'd1:    row_offset = 8'h40;
      2'd2:    row_offset = 8'(columns);
      default: row_offset = 8'(32'h40 + columns);
    endcase
  endfunction

  function automatic phase_e phase_of(input step_e step);
    case (step)
      STEP_POWERUP:                phase_of = PHASE_POWERUP;
      STEP_ROW_ADDR, STEP_ROW_DATA: phase_of = PHASE_REFRESH;
      default:                     phase_of = PHASE_INIT;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD bus transaction: SETUP (1 clk), E PULSE, then HOLD for the requested wait.
module lcd_bus_cycle #(
  parameter int E_PULSE_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rs,
  input  logic [7:0]  db,
  input  logic [31:0] wait_cycles,
  output logic        busy,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic [7:0]  lcd_db
);
  import lcd_pkg::*;

  bus_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  db_q, db_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    done    = (state_q == BUS_HOLD) && (cnt_q == wait_q - 32'd1);
    busy    = (state_q != BUS_IDLE);
    case (state_q)
      BUS_SETUP: begin
        state_d = BUS_PULSE;
        cnt_d   = '0;
        e_d     = 1'b1;
      end
      BUS_PULSE: begin
        if (cnt_q == 32'(E_PULSE_CYCLES - 1)) begin
          state_d = BUS_HOLD;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BUS_HOLD: begin
        if (done) state_d = BUS_IDLE;
        else      cnt_d   = cnt_q + 32'd1;
      end
      default: ;
    endcase
    // A new request is taken in the last HOLD cycle so transactions run back to back.
    if (start && (!busy || done)) begin
      state_d = BUS_SETUP;
      cnt_d   = '0;
      e_d     = 1'b0;
      rs_d    = rs;
      db_d    = db;
      wait_d  = wait_cycles;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_text_display.sv
// HD44780 8-bit driver: power-on init, then endless refresh of a ROWS x COLUMNS buffer.
module lcd_text_display #(
  parameter int COLUMNS             = 16,
  parameter int ROWS                = 2,
  parameter int E_PULSE_CYCLES      = 12,
  parameter int CMD_WAIT_CYCLES     = 2000,
  parameter int CLEAR_WAIT_CYCLES   = 82000,
  parameter int POWERUP_WAIT_CYCLES = 750000,
  parameter int INIT_WAIT1_CYCLES   = 205000,
  parameter int INIT_WAIT2_CYCLES   = 5000,
  localparam int DEPTH = ROWS * COLUMNS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLOCK_50MHZ,
  input  logic          RESET_N,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [7:0]    WR_DATA,
  output logic          READY,
  output logic [7:0]    LCD_DATA_BIT,
  output logic          LCD_ENABLE,
  output logic          LCD_REGISTER_SELECT,
  output logic          LCD_READ_WRITE,
  output logic [7:0]    LED
);
  import lcd_pkg::*;

  step_e         step_q, step_d;
  logic [1:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic [31:0]   pwr_cnt_q, pwr_cnt_d;
  logic          ready_q, ready_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    buffer_q [DEPTH];
  logic [7:0]    buffer_d [DEPTH];
  logic          has_txn, issue, txn_rs, bus_busy, bus_done;
  logic [7:0]    txn_db;
  logic [31:0]   txn_wait;
  logic [AW-1:0] rd_addr;

  assign rd_addr = AW'(int'(row_q) * COLUMNS + int'(col_q));

  always_comb begin
    buffer_d = buffer_q;
    if (WR_EN && (32'(WR_ADDR) < 32'(DEPTH))) buffer_d[WR_ADDR] = WR_DATA;
  end

  always_comb begin
    step_d    = step_q;
    row_d     = row_q;
    col_d     = col_q;
    pwr_cnt_d = pwr_cnt_q;
    has_txn   = 1'b1;
    txn_rs    = 1'b0;
    txn_db    = CMD_FUNCTION_SET;
    txn_wait  = 32'(CMD_WAIT_CYCLES);
    case (step_q)
      STEP_POWERUP: begin
        pwr_cnt_d = pwr_cnt_q + 32'd1;
        has_txn   = (pwr_cnt_q == 32'(POWERUP_WAIT_CYCLES - 1));
        txn_wait  = 32'(INIT_WAIT1_CYCLES);
      end
      STEP_INIT_1:   txn_wait = 32'(INIT_WAIT2_CYCLES);
      STEP_INIT_4:   txn_db   = CMD_ENTRY_MODE;
      STEP_INIT_5:   txn_db   = CMD_DISPLAY_ON;
      STEP_INIT_6: begin
        txn_db   = CMD_CLEAR;
        txn_wait = 32'(CLEAR_WAIT_CYCLES);
      end
      STEP_ROW_ADDR: txn_db = CMD_SET_DDRAM | row_offset(row_q, COLUMNS);
      STEP_ROW_DATA: begin
        txn_rs = 1'b1;
        txn_db = buffer_q[rd_addr];
      end
      default: ;
    endcase

    issue = has_txn && (!bus_busy || bus_done);
    if (issue) begin
      case (step_q)
        STEP_POWERUP: step_d = STEP_INIT_1;
        STEP_INIT_1:  step_d = STEP_INIT_2;
        STEP_INIT_2:  step_d = STEP_INIT_3;
        STEP_INIT_3:  step_d = STEP_INIT_4;
        STEP_INIT_4:  step_d = STEP_INIT_5;
        STEP_INIT_5:  step_d = STEP_INIT_6;
        STEP_INIT_6: begin
          step_d = STEP_ROW_ADDR;
          row_d  = 2'd0;
          col_d  = 6'd0;
        end
        STEP_ROW_ADDR: step_d = STEP_ROW_DATA;
        STEP_ROW_DATA: begin
          if (col_q == 6'(COLUMNS - 1)) begin
            col_d  = 6'd0;
            step_d = STEP_ROW_ADDR;
            row_d  = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
        default: step_d = STEP_POWERUP;
      endcase
    end

    // The first bus completion seen in the refresh phase is the end of the clear HOLD.
    ready_d = ready_q | (bus_done && (phase_of(step_q) == PHASE_REFRESH));
    led_d   = {phase_of(step_q), step_q};
  end

  always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      step_q    <= STEP_POWERUP;
      row_q     <= 2'd0;
      col_q     <= 6'd0;
      pwr_cnt_q <= '0;
      ready_q   <= 1'b0;
      led_q     <= 8'hFF;
      for (int i = 0; i < DEPTH; i++) buffer_q[i] <= 8'h20;
    end else begin
      step_q    <= step_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pwr_cnt_q <= pwr_cnt_d;
      ready_q   <= ready_d;
      led_q     <= led_d;
      buffer_q  <= buffer_d;
    end
  end

  lcd_bus_cycle #(
    .E_PULSE_CYCLES(E_PULSE_CYCLES)
  ) u_bus (
    .clk         (CLOCK_50MHZ),
    .rst_n       (RESET_N),
    .start       (has_txn),
    .rs          (txn_rs),
    .db          (txn_db),
    .wait_cycles (txn_wait),
    .busy        (bus_busy),
    .done        (bus_done),
    .lcd_e       (LCD_ENABLE),
    .lcd_rs      (LCD_REGISTER_SELECT),
    .lcd_db      (LCD_DATA_BIT)
  );

  assign READY          = ready_q;
  assign LED            = led_q;
  assign LCD_READ_WRITE = 1'b0;

endmodule
